// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer for the 4-bank byte-lane data memory.
// Handles one request at a time: access, optional capture/extend, then response.
module dmem_lsu_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DMEM_AW = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [3:0]         req_op,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [31:0]        req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_err,
    output logic [DMEM_AW-1:0] dmem_daddr,
    output logic [3:0]         dmem_we,
    output logic [31:0]        dmem_indata,
    input  logic [31:0]        dmem_outdata
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCESS  = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    logic [1:0]         state, state_nxt;
    logic [3:0]         op_q, op_nxt;
    logic [1:0]         lane_q, lane_nxt;
    logic               req_ready_nxt;
    logic               rsp_valid_nxt;
    logic [31:0]        rsp_rdata_nxt;
    logic               rsp_err_nxt;
    logic [DMEM_AW-1:0] dmem_daddr_nxt;
    logic [3:0]         dmem_we_nxt;
    logic [31:0]        dmem_indata_nxt;

    logic               op_legal;
    logic               misalign;
    logic               out_of_range;
    logic               req_bad;
    logic [3:0]         store_we;
    logic [31:0]        store_data;
    logic [31:0]        shifted;
    logic [31:0]        load_data;

    // Request legality, alignment and range checks.
    always_comb begin
        if (req_op[3]) begin
            op_legal = req_op[2:0] inside {3'b000, 3'b001, 3'b010};
        end else begin
            op_legal = req_op[2:0] inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end
        misalign     = ((req_op[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_op[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        out_of_range = (req_addr >> (DMEM_AW + 2)) != '0;
        req_bad      = !op_legal || misalign || out_of_range;
    end

    // Byte-lane enables and lane-replicated store data.
    always_comb begin
        case (req_op[1:0])
            2'b00: begin
                store_we   = 4'b0001 << req_addr[1:0];
                store_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                store_we   = req_addr[1] ? 4'b1100 : 4'b0011;
                store_data = {2{req_wdata[15:0]}};
            end
            default: begin
                store_we   = 4'b1111;
                store_data = req_wdata;
            end
        endcase
    end

    // Lane extraction and sign/zero extension of the read word.
    assign shifted = dmem_outdata >> {lane_q, 3'b000};

    always_comb begin
        case (op_q[2:0])
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_data = shifted;
            3'b100:  load_data = {24'd0, shifted[7:0]};
            3'b101:  load_data = {16'd0, shifted[15:0]};
            default: load_data = 32'd0;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt       = state;
        op_nxt          = op_q;
        lane_nxt        = lane_q;
        req_ready_nxt   = req_ready;
        rsp_valid_nxt   = rsp_valid;
        rsp_rdata_nxt   = rsp_rdata;
        rsp_err_nxt     = rsp_err;
        dmem_daddr_nxt  = dmem_daddr;
        dmem_we_nxt     = 4'b0000;
        dmem_indata_nxt = dmem_indata;

        case (state)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    op_nxt         = req_op;
                    lane_nxt       = req_addr[1:0];
                    dmem_daddr_nxt = req_addr[DMEM_AW+1:2];
                    req_ready_nxt  = 1'b0;
                    if (req_bad) begin
                        state_nxt     = ST_RESP;
                        rsp_valid_nxt = 1'b1;
                        rsp_err_nxt   = 1'b1;
                        rsp_rdata_nxt = 32'd0;
                    end else begin
                        state_nxt = ST_ACCESS;
                        if (req_op[3]) begin
                            dmem_we_nxt     = store_we;
                            dmem_indata_nxt = store_data;
                        end
                    end
                end
            end
            ST_ACCESS: begin
                if (op_q[3]) begin
                    state_nxt     = ST_RESP;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b0;
                    rsp_rdata_nxt = 32'd0;
                end else begin
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_nxt     = ST_RESP;
                rsp_valid_nxt = 1'b1;
                rsp_err_nxt   = 1'b0;
                rsp_rdata_nxt = load_data;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt     = ST_IDLE;
                    rsp_valid_nxt = 1'b0;
                    rsp_err_nxt   = 1'b0;
                    req_ready_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt     = ST_IDLE;
                rsp_valid_nxt = 1'b0;
                rsp_err_nxt   = 1'b0;
                req_ready_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            op_q        <= 4'd0;
            lane_q      <= 2'd0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 32'd0;
            rsp_err     <= 1'b0;
            dmem_daddr  <= '0;
            dmem_we     <= 4'b0000;
            dmem_indata <= 32'd0;
        end else begin
            state       <= state_nxt;
            op_q        <= op_nxt;
            lane_q      <= lane_nxt;
            req_ready   <= req_ready_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_rdata   <= rsp_rdata_nxt;
            rsp_err     <= rsp_err_nxt;
            dmem_daddr  <= dmem_daddr_nxt;
            dmem_we     <= dmem_we_nxt;
            dmem_indata <= dmem_indata_nxt;
        end
    end

endmodule

// File: doc/dmem_lsu_ctrl.md
Name: dmem_lsu_ctrl

Overview:
- Load/store sequencer in front of the byte-lane data memory `dmem`. `dmem` has 4 byte banks with per-lane write enables and a registered read port.
- Accepts one load/store request at a time over a valid/ready handshake.
- Generates the word address, the byte-lane `we[3:0]` and the lane-replicated write data.
- Sign- or zero-extends load data and returns it over a valid/ready response channel.
- Sits between the core's memory stage and `dmem`.

Parameters:
- ADDR_W, 32, width of the byte address from the requester.
- DMEM_AW, 10, `dmem` word-address width; must equal `dmem_addr.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_op  input  4  {is_store, funct3}. funct3: 000=B, 001=H, 010=W, 100=BU, 101=HU.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-justified.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts response.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  request was illegal, misaligned or out of range.
- dmem_daddr  output  DMEM_AW  word address to `dmem`.
- dmem_we  output  4  byte-lane write enables to `dmem`.
- dmem_indata  output  32  write data to `dmem`.
- dmem_outdata  input  32  registered read data from `dmem`.

Behaviour:
- Reset values:
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0.
  - rsp_rdata=0, dmem_we=0, dmem_daddr=0, dmem_indata=0.
- All dmem_* outputs are registered. dmem_we is nonzero only in ACCESS for stores, and for exactly one cycle.
- States:
  - IDLE: req_ready=1; the only state that accepts a request.
  - ACCESS: dmem_* driven; the dmem clock edge performs the read or write.
  - CAPTURE: loads only; dmem_outdata is valid and gets extracted.
  - RESP: rsp_valid=1; holds until rsp_ready.
- Accept (edge E0, req_valid & req_ready):
  - Latch op and addr[1:0]; dmem_daddr <= req_addr[DMEM_AW+1:2].
  - Error checks:
    - illegal op: store funct3 not in {000,001,010}; load funct3 not in {000,001,010,100,101}.
    - H/HU with addr[0]=1.
    - W with addr[1:0]!=0.
    - addr[ADDR_W-1:DMEM_AW+2] != 0.
  - On error: go to RESP with rsp_err=1, rsp_rdata=0, dmem_we stays 0. rsp_valid is visible after E0, i.e. 1-cycle latency.
- Store: E0 -> ACCESS with
  - SB: we=1<<addr[1:0], indata={4{wdata[7:0]}}.
  - SH: we=addr[1]?4'b1100:4'b0011, indata={2{wdata[15:0]}}.
  - SW: we=4'b1111, indata=wdata.
  - At E1 dmem writes, we<=0, go to RESP with rsp_err=0. Latency: rsp_valid after E1.
- Load: E0 -> ACCESS with we=0. At E1 dmem updates outdata -> CAPTURE.
  - At E2, extract the lane from dmem_outdata >> (8*addr[1:0]).
  - B/H sign-extend; BU/HU zero-extend; W passes through. Register into rsp_rdata -> RESP.
  - Latency: rsp_valid after E2.
- RESP:
  - Hold rsp_valid, rsp_rdata and rsp_err stable while rsp_ready=0.
  - On rsp_ready: go to IDLE, rsp_valid<=0, rsp_err<=0.
  - req_ready returns to 1 the next cycle; there is no request/response overlap.
- req_valid while not in IDLE is ignored; the requester must hold the request.
- Reset mid-operation:
  - Reset in any state returns to IDLE on that edge and drops any pending response.
  - If reset is asserted at the E1 edge of a store, dmem still sees the registered we at that edge, so the write commits. dmem_we is 0 after that edge.
- Reset has priority over the request handshake on the same edge.

Test Plan:
- Reset, then SW addr=0x10 data=0xDEADBEEF -> dmem_daddr=4, we=1111 for 1 cycle, rsp_valid 2 cycles after accept, rsp_err=0.
- After the SW, LB at 0x13 -> rsp_rdata=0xFFFFFFDE 3 cycles after accept; LBU at 0x13 -> 0x000000DE; LH at 0x12 -> 0xFFFFDEAD; LW at 0x10 -> 0xDEADBEEF.
- SB 0x55 at 0x11 then LW 0x10 -> we=0010, indata=0x55555555, readback 0xDEAD55EF.
- LH at 0x11, SW at 0x12, store funct3=100, addr=0x00001000 (DMEM_AW=10) -> each gives rsp_err=1 after 1 cycle, dmem_we never nonzero, rsp_rdata=0.
- LW with rsp_ready held 0 for 5 cycles -> rsp_valid and data stable, req_ready=0 throughout, a new req_valid is not accepted until 1 cycle after the response handshake.
- Assert reset during CAPTURE of a load -> next cycle state IDLE, rsp_valid=0, req_ready=1; a follow-on LW returns correct data.
